// File: rtl/gb_fb_pkg.sv
// Shared types and constants for the GameBoy frame-buffer write path.
// Contents: fb_state_e (writer FSM states), page_t (frame page index),
// GB_H/GB_V (native LCD resolution), fb_frame_size() (pixels per page).
package gb_fb_pkg;

   typedef enum logic [1:0] {
      WAIT_SYNC,
      ACTIVE,
      DONE,
      SKIP
   } fb_state_e;

   typedef logic [1:0] page_t;

   localparam int unsigned GB_H = 160;
   localparam int unsigned GB_V = 144;

   function automatic int unsigned fb_frame_size(input int unsigned h, input int unsigned v);
      return h * v;
   endfunction

endpackage

// File: rtl/gb_page_sync.sv
// Brings the VGA reader's page index into the GameBoy_clk domain.
// Two-flop synchroniser followed by a stability filter: the output only takes a
// new value after two consecutive equal synchronised samples, so a multi-bit
// transition caught mid-change never reaches the page chooser.
// Ports:
//   GameBoy_clk     in   GameBoy clock
//   GameBoy_reset   in   asynchronous active-high reset
//   rd_page_i       in   page index from the VGA domain
//   rd_page_sync_o  out  filtered page index in the GameBoy_clk domain
module gb_page_sync
   import gb_fb_pkg::*;
(
   input  logic  GameBoy_clk,
   input  logic  GameBoy_reset,
   input  page_t rd_page_i,
   output page_t rd_page_sync_o
);

   page_t meta_q, sync_q, prev_q, stable_q, stable_d;

   always_comb begin
      stable_d = stable_q;
      if (sync_q == prev_q) stable_d = sync_q;
   end

   always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
      if (GameBoy_reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         prev_q   <= '0;
         stable_q <= '0;
      end else begin
         meta_q   <= rd_page_i;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         stable_q <= stable_d;
      end
   end

   assign rd_page_sync_o = stable_q;

endmodule

// File: rtl/gb_frame_writer.sv
// Write-side controller for the GameBoy LCD frame buffer (GameBoy_clk domain).
// Counts LCD pixels into a 2- or 3-page buffer, resynchronises on lcd_vsync and
// publishes completed pages to the VGA scaler without tearing.
// Optional statistics counters are built when GB_FB_STATS_EN is defined;
// otherwise frame_cnt/drop_cnt are tied to zero.
// Ports:
//   GameBoy_clk, GameBoy_reset   clock, asynchronous active-high reset
//   LD, PX_VALID                 LCD pixel data and its valid strobe
//   lcd_vsync, lcd_on            LCD frame-start pulse and LCD enable
//   rd_page                      page the VGA reader scans (VGA domain)
//   fb_we, fb_addr, fb_data      frame RAM write port (1-cycle latency)
//   disp_page, disp_valid        latest complete page and its validity
//   frame_done                   one-cycle pulse on publish
//   err_sticky                   [0] short frame, [1] overrun
//   frame_cnt, drop_cnt          published / skipped frame counters
module gb_frame_writer
   import gb_fb_pkg::*;
#(
   parameter int unsigned H_PIXELS  = GB_H,
   parameter int unsigned V_PIXELS  = GB_V,
   parameter int unsigned PIX_W     = 2,
   parameter int unsigned NUM_PAGES = 2,
   parameter int unsigned ADDR_W    = $clog2(NUM_PAGES * H_PIXELS * V_PIXELS)
) (
   input  logic              GameBoy_clk,
   input  logic              GameBoy_reset,
   input  logic [PIX_W-1:0]  LD,
   input  logic              PX_VALID,
   input  logic              lcd_vsync,
   input  logic              lcd_on,
   input  logic [1:0]        rd_page,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_data,
   output logic [1:0]        disp_page,
   output logic              disp_valid,
   output logic              frame_done,
   output logic [1:0]        err_sticky,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       drop_cnt
);

   localparam int unsigned FRAME = fb_frame_size(H_PIXELS, V_PIXELS);
   localparam int unsigned CNT_W = $clog2(FRAME);
   localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME - 1);

   // Page bases are constants, so no run-time multiplier is needed.
   function automatic logic [ADDR_W-1:0] page_base(input page_t p);
      case (p)
         2'd1:    page_base = ADDR_W'(FRAME);
         2'd2:    page_base = ADDR_W'(2 * FRAME);
         default: page_base = '0;
      endcase
   endfunction

   fb_state_e         state_q, state_d;
   page_t             wr_page_q, wr_page_d, disp_page_q, disp_page_d;
   logic [ADDR_W-1:0] base_q, base_d, fb_addr_q, fb_addr_d;
   logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
   logic              disp_valid_q, disp_valid_d, frame_done_q, frame_done_d;
   logic              fb_we_q, fb_we_d;
   logic [PIX_W-1:0]  fb_data_q, fb_data_d;
   logic [1:0]        err_q, err_d;
   page_t             rd_page_sync, pick_disp, free_page;
   logic              free_ok, start, skip_entry;

   gb_page_sync u_page_sync (
      .GameBoy_clk    (GameBoy_clk),
      .GameBoy_reset  (GameBoy_reset),
      .rd_page_i      (rd_page),
      .rd_page_sync_o (rd_page_sync)
   );

   // A vsync on the last pixel chooses against the page being published now.
   assign pick_disp = (state_q == ACTIVE) ? wr_page_q : disp_page_q;

   always_comb begin
      free_ok   = 1'b0;
      free_page = '0;
      for (int unsigned p = 0; p < NUM_PAGES; p++) begin
         if (!free_ok && page_t'(p) != pick_disp && page_t'(p) != rd_page_sync) begin
            free_ok   = 1'b1;
            free_page = page_t'(p);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_page_d    = wr_page_q;
      base_d       = base_q;
      pix_cnt_d    = pix_cnt_q;
      disp_page_d  = disp_page_q;
      disp_valid_d = disp_valid_q;
      frame_done_d = 1'b0;
      fb_we_d      = 1'b0;
      fb_addr_d    = fb_addr_q;
      fb_data_d    = fb_data_q;
      err_d        = err_q;
      start        = 1'b0;
      skip_entry   = 1'b0;

      if (!lcd_on) begin
         state_d      = WAIT_SYNC;
         disp_valid_d = 1'b0;
         pix_cnt_d    = '0;
      end else begin
         unique case (state_q)
            WAIT_SYNC: start = lcd_vsync;
            ACTIVE: begin
               if (PX_VALID) begin
                  fb_we_d   = 1'b1;
                  fb_addr_d = base_q + ADDR_W'(pix_cnt_q);
                  fb_data_d = LD;
               end
               if (PX_VALID && pix_cnt_q == LAST_PIX) begin
                  disp_page_d  = wr_page_q;
                  disp_valid_d = 1'b1;
                  frame_done_d = 1'b1;
                  pix_cnt_d    = '0;
                  state_d      = DONE;
                  start        = lcd_vsync;
               end else if (lcd_vsync) begin
                  err_d[0]  = 1'b1;
                  pix_cnt_d = '0;
               end else if (PX_VALID) begin
                  pix_cnt_d = pix_cnt_q + 1'b1;
               end
            end
            DONE: begin
               if (PX_VALID) err_d[1] = 1'b1;
               start = lcd_vsync;
            end
            SKIP: start = lcd_vsync;
         endcase

         if (start) begin
            if (free_ok) begin
               state_d   = ACTIVE;
               wr_page_d = free_page;
               base_d    = page_base(free_page);
               pix_cnt_d = '0;
            end else begin
               state_d    = SKIP;
               skip_entry = (state_q != SKIP);
            end
         end
      end
   end

   always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
      if (GameBoy_reset) begin
         state_q      <= WAIT_SYNC;
         wr_page_q    <= '0;
         base_q       <= '0;
         pix_cnt_q    <= '0;
         disp_page_q  <= '0;
         disp_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
         fb_we_q      <= 1'b0;
         fb_addr_q    <= '0;
         fb_data_q    <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         wr_page_q    <= wr_page_d;
         base_q       <= base_d;
         pix_cnt_q    <= pix_cnt_d;
         disp_page_q  <= disp_page_d;
         disp_valid_q <= disp_valid_d;
         frame_done_q <= frame_done_d;
         fb_we_q      <= fb_we_d;
         fb_addr_q    <= fb_addr_d;
         fb_data_q    <= fb_data_d;
         err_q        <= err_d;
      end
   end

   assign fb_we      = fb_we_q;
   assign fb_addr    = fb_addr_q;
   assign fb_data    = fb_data_q;
   assign disp_page  = disp_page_q;
   assign disp_valid = disp_valid_q;
   assign frame_done = frame_done_q;
   assign err_sticky = err_q;

`ifdef GB_FB_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q + {15'd0, frame_done_d};
      drop_cnt_d  = drop_cnt_q + {15'd0, skip_entry};
   end

   always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
      if (GameBoy_reset) begin
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`else
   logic unused_stats;
   assign unused_stats = skip_entry;
   assign frame_cnt    = '0;
   assign drop_cnt     = '0;
`endif

endmodule

// File: tb/tb_gb_frame_writer.sv
// Directed bench for gb_frame_writer. A 2-page and a 3-page instance share one
// stimulus stream; expected addresses, pages and error bits are hand-derived.
module tb_gb_frame_writer;

`ifdef GB_FB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, pxv, vs, on;
   logic [1:0]  ld, rd;

   logic        we2, dv2, fd2, we3, dv3, fd3;
   logic [15:0] addr2;
   logic [16:0] addr3;
   logic [1:0]  data2, disp2, err2, data3, disp3, err3;
   logic [15:0] fc2, dc2, fc3, dc3;

   int tests = 0;
   int fails = 0;
   int fd2_cnt = 0;
   int fd3_cnt = 0;
   int bad;

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (fd2 === 1'b1) fd2_cnt <= fd2_cnt + 1;
      if (fd3 === 1'b1) fd3_cnt <= fd3_cnt + 1;
   end

   gb_frame_writer #(.NUM_PAGES(2)) u_dut2 (
      .GameBoy_clk   (clk),
      .GameBoy_reset (rst),
      .LD            (ld),
      .PX_VALID      (pxv),
      .lcd_vsync     (vs),
      .lcd_on        (on),
      .rd_page       (rd),
      .fb_we         (we2),
      .fb_addr       (addr2),
      .fb_data       (data2),
      .disp_page     (disp2),
      .disp_valid    (dv2),
      .frame_done    (fd2),
      .err_sticky    (err2),
      .frame_cnt     (fc2),
      .drop_cnt      (dc2)
   );

   gb_frame_writer #(.NUM_PAGES(3)) u_dut3 (
      .GameBoy_clk   (clk),
      .GameBoy_reset (rst),
      .LD            (ld),
      .PX_VALID      (pxv),
      .lcd_vsync     (vs),
      .lcd_on        (on),
      .rd_page       (rd),
      .fb_we         (we3),
      .fb_addr       (addr3),
      .fb_data       (data3),
      .disp_page     (disp3),
      .disp_valid    (dv3),
      .frame_done    (fd3),
      .err_sticky    (err3),
      .frame_cnt     (fc3),
      .drop_cnt      (dc3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives n consecutive pixels (LD = i%4) and counts per-pixel write errors.
   task automatic stream(input int n, input int base2, input bit exp_we2,
                         input int base3, input bit exp_we3, output int nbad);
      nbad = 0;
      for (int i = 0; i < n; i++) begin
         pxv = 1'b1;
         ld  = 2'(i % 4);
         tick();
         if (exp_we2) begin
            if (we2 !== 1'b1 || addr2 !== 16'(base2 + i) || data2 !== 2'(i % 4)) nbad++;
         end else if (we2 !== 1'b0) nbad++;
         if (exp_we3) begin
            if (we3 !== 1'b1 || addr3 !== 17'(base3 + i) || data3 !== 2'(i % 4)) nbad++;
         end else if (we3 !== 1'b0) nbad++;
      end
      pxv = 1'b0;
   endtask

   task automatic pulse_vsync();
      vs = 1'b1;
      tick();
      vs = 1'b0;
   endtask

   initial begin
      rst = 1'b1; on = 1'b0; pxv = 1'b0; vs = 1'b0; ld = '0; rd = '0;
      tick();
      tick();
      check("reset outputs dut2", 64'({we2, addr2, data2, disp2, dv2, fd2, err2, fc2, dc2}), 64'd0);
      check("reset outputs dut3", 64'({we3, addr3, data3, disp3, dv3, fd3, err3, fc3, dc3}), 64'd0);

      // Frame 1: both instances pick page 1.
      rst = 1'b0; on = 1'b1;
      tick();
      tick();
      pulse_vsync();
      check("no write on vsync", 64'({we2, we3}), 64'd0);
      stream(23040, 23040, 1'b1, 23040, 1'b1, bad);
      check("frame1 stream", 64'(bad), 64'd0);
      check("frame1 last addr", 64'(addr2), 64'd46079);
      check("frame1 frame_done", 64'({fd2, fd3}), 64'b11);
      check("frame1 disp_page dut2", 64'(disp2), 64'd1);
      check("frame1 disp_page dut3", 64'(disp3), 64'd1);
      check("frame1 disp_valid", 64'({dv2, dv3}), 64'b11);
      tick();
      check("frame_done pulse", 64'({fd2, fd3}), 64'd0);
      check("frame_done count dut2 f1", 64'(fd2_cnt), 64'd1);
      check("frame_done count dut3 f1", 64'(fd3_cnt), 64'd1);
      check("frame_cnt dut2 f1", 64'(fc2), STATS ? 64'd1 : 64'd0);

      // rd=0, disp=1: 2-page skips, 3-page writes page 2.
      pulse_vsync();
      stream(100, 0, 1'b0, 46080, 1'b1, bad);
      check("skip / page2 stream", 64'(bad), 64'd0);
      check("drop_cnt dut2 skip", 64'(dc2), STATS ? 64'd1 : 64'd0);
      check("drop_cnt dut3 none", 64'(dc3), 64'd0);

      rd = 2'd1;
      repeat (8) tick();
      pulse_vsync();
      check("err dut2 after retry", 64'(err2), 64'd0);
      check("err dut3 short frame", 64'(err3), 64'd1);

      // Short frame on page 0 for the 2-page instance.
      stream(100, 0, 1'b1, 46080, 1'b1, bad);
      check("short frame stream", 64'(bad), 64'd0);
      pulse_vsync();
      check("err dut2 short frame", 64'(err2), 64'd1);
      tick();
      check("no publish dut2 short", 64'(fd2_cnt), 64'd1);
      check("no publish dut3 short", 64'(fd3_cnt), 64'd1);

      stream(23040, 0, 1'b1, 46080, 1'b1, bad);
      check("restart at base stream", 64'(bad), 64'd0);
      check("disp_page dut2 page0", 64'(disp2), 64'd0);
      check("disp_page dut3 page2", 64'(disp3), 64'd2);

      // Overrun pixel while in DONE.
      pxv = 1'b1; ld = 2'd1;
      tick();
      pxv = 1'b0;
      check("overrun no write", 64'({we2, we3}), 64'd0);
      check("overrun addr held", 64'(addr2), 64'd23039);
      check("overrun err dut2", 64'(err2), 64'd3);
      check("overrun err dut3", 64'(err3), 64'd3);
      tick();
      check("frame_done count dut2 f2", 64'(fd2_cnt), 64'd2);

      // Vsync coinciding with the last pixel.
      rd = 2'd0;
      repeat (8) tick();
      pulse_vsync();
      stream(23039, 23040, 1'b1, 23040, 1'b1, bad);
      check("coincident pre stream", 64'(bad), 64'd0);
      pxv = 1'b1; ld = 2'd3; vs = 1'b1;
      tick();
      vs = 1'b0;
      check("coincident last write dut2", 64'({we2, addr2, data2, fd2, disp2}),
            64'({1'b1, 16'd46079, 2'd3, 1'b1, 2'd1}));
      check("coincident last write dut3", 64'({we3, addr3, fd3, disp3}),
            64'({1'b1, 17'd46079, 1'b1, 2'd1}));
      ld = 2'd0;
      tick();
      check("coincident next dut2 skip", 64'(we2), 64'd0);
      check("coincident next dut3 page2", 64'({we3, addr3}), 64'({1'b1, 17'd46080}));
      check("frame_done count dut2 f3", 64'(fd2_cnt), 64'd3);
      check("drop_cnt dut2 f3", 64'(dc2), STATS ? 64'd2 : 64'd0);
      check("frame_cnt dut3 f3", 64'(fc3), STATS ? 64'd3 : 64'd0);

      // lcd_on falls mid-frame.
      ld = 2'd1;
      tick();
      ld = 2'd2; on = 1'b0;
      tick();
      check("lcd_off no write", 64'({we2, we3}), 64'd0);
      check("lcd_off disp_valid", 64'({dv2, dv3}), 64'd0);
      check("lcd_off err held", 64'(err2), 64'd3);
      check("lcd_off disp_page held", 64'(disp3), 64'd1);
      pxv = 1'b0; on = 1'b1;
      tick();
      pulse_vsync();
      pxv = 1'b1; ld = 2'd2;
      tick();
      check("relock dut3 page2", 64'({we3, addr3}), 64'({1'b1, 17'd46080}));

      // Asynchronous reset mid-ACTIVE, away from any clock edge.
      #1 rst = 1'b1;
      #1;
      check("async reset dut2", 64'({we2, addr2, data2, disp2, dv2, fd2, err2, fc2, dc2}), 64'd0);
      check("async reset dut3", 64'({we3, addr3, data3, disp3, dv3, fd3, err3, fc3, dc3}), 64'd0);
      pxv = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
